// File: rtl/gold_pkg.sv
// Shared types and default sizing for the Gold-code shift scheduler.
package gold_pkg;

   localparam int NUM_REQ      = 4;
   localparam int SHIFT_W      = 6;
   localparam int CODE_LEN     = 63;
   localparam int EPOCH_CYCLES = 100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_BUSY = 2'd2
   } sched_state_t;

endpackage

// File: rtl/gold_shift_sched_rr_arbiter.sv
// Round-robin pick: first eligible channel at or above rr_ptr, wrapping upward.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk from the farthest offset down so the nearest eligible channel wins.
   always_comb begin
      valid    = 1'b0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = cand[IDX_W-1:0];
         if (eligible[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/gold_shift_sched.sv
// Shares one Gold-code generator among NUM_REQ channels, one code per channel per epoch.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for an eligible (requesting, unserved) channel
// ST_SEND | offering the latched shift until the generator accepts it
// ST_BUSY | generator producing the code, CODE_LEN cycles
module gold_shift_sched #(
   parameter int NUM_REQ      = gold_pkg::NUM_REQ,
   parameter int SHIFT_W      = gold_pkg::SHIFT_W,
   parameter int CODE_LEN     = gold_pkg::CODE_LEN,
   parameter int EPOCH_CYCLES = gold_pkg::EPOCH_CYCLES
) (
   input  logic                       clkin,
   input  logic                       rstn,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SHIFT_W-1:0] req_shift,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [SHIFT_W-1:0]         m_tdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       epoch_tick,
   output logic [NUM_REQ-1:0]         served,
   output logic                       busy,
   output logic                       miss_err,
   input  logic                       err_clr
);
   import gold_pkg::*;

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int EPOCH_W = $clog2(EPOCH_CYCLES);
   localparam int BUSY_W  = $clog2(CODE_LEN + 1);

   sched_state_t        state_q, state_d;
   logic [EPOCH_W-1:0]  epoch_cnt_q;
   logic                epoch_tick_q;
   logic [BUSY_W-1:0]   busy_cnt_q;
   logic [IDX_W-1:0]    rr_ptr_q, winner_q, next_ptr, arb_idx;
   logic [SHIFT_W-1:0]  shift_q;
   logic [NUM_REQ-1:0]  served_q, served_d, eligible, winner_oh;
   logic                miss_err_q, arb_valid, hs;

   assign eligible = req & ~served_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .valid    (arb_valid),
      .idx      (arb_idx)
   );

   assign hs       = (state_q == ST_SEND) && m_tready;
   assign next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

   always_comb begin
      winner_oh           = '0;
      winner_oh[winner_q] = 1'b1;
   end

   assign gnt        = hs ? winner_oh : '0;
   assign m_tvalid   = (state_q == ST_SEND);
   assign m_tdata    = shift_q;
   assign busy       = (state_q != ST_IDLE);
   assign epoch_tick = epoch_tick_q;
   assign served     = served_q;
   assign miss_err   = miss_err_q;

   // A grant landing on the epoch boundary survives the clear.
   assign served_d = (epoch_tick_q ? '0 : served_q) | gnt;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (arb_valid)           state_d = ST_SEND;
         ST_SEND: if (m_tready)            state_d = ST_BUSY;
         ST_BUSY: if (busy_cnt_q == '0)    state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         winner_q   <= '0;
         shift_q    <= '0;
         rr_ptr_q   <= '0;
         busy_cnt_q <= '0;
         served_q   <= '0;
      end else begin
         served_q <= served_d;
         if (state_q == ST_IDLE && arb_valid) begin
            winner_q <= arb_idx;
            shift_q  <= req_shift[arb_idx*SHIFT_W +: SHIFT_W];
         end
         if (hs) begin
            busy_cnt_q <= BUSY_W'(CODE_LEN - 1);
            rr_ptr_q   <= next_ptr;
         end else if (state_q == ST_BUSY && busy_cnt_q != '0) begin
            busy_cnt_q <= busy_cnt_q - 1'b1;
         end
      end
   end

   // Free-running epoch timer; the tick is registered so it appears EPOCH_CYCLES edges after reset.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         epoch_cnt_q  <= EPOCH_W'(EPOCH_CYCLES - 1);
         epoch_tick_q <= 1'b0;
      end else if (epoch_cnt_q == '0) begin
         epoch_cnt_q  <= EPOCH_W'(EPOCH_CYCLES - 1);
         epoch_tick_q <= 1'b1;
      end else begin
         epoch_cnt_q  <= epoch_cnt_q - 1'b1;
         epoch_tick_q <= 1'b0;
      end
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn)                               miss_err_q <= 1'b0;
      else if (epoch_tick_q && |(req & ~served_q)) miss_err_q <= 1'b1;
      else if (err_clr)                        miss_err_q <= 1'b0;
   end

endmodule

// File: doc/gold_shift_sched.md
GOLD_SHIFT_SCHED -- requirements
Module: gold_shift_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 4, number of requesting channels.
- SHIFT_W, 6, code-shift width.
- CODE_LEN, 63, generator busy cycles per code.
- EPOCH_CYCLES, 100000, epoch length in cycles (1 ms).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clkin, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- req, in, NUM_REQ, per-channel code request (level).
- req_shift, in, NUM_REQ*SHIFT_W, channel i shift in bits [i*SHIFT_W +: SHIFT_W].
- m_tvalid, out, 1, shift valid to Gold generator.
- m_tready, in, 1, generator ready.
- m_tdata, out, SHIFT_W, granted shift.
- gnt, out, NUM_REQ, one-hot grant pulse.
- epoch_tick, out, 1, one-cycle epoch boundary pulse.
- served, out, NUM_REQ, channels served this epoch.
- busy, out, 1, FSM not in IDLE.
- miss_err, out, 1, sticky missed-request flag.
- err_clr, in, 1, clears miss_err.

Function
REQ-003 Block SHALL share one Gold code generator among NUM_REQ channels, at most one code per channel per epoch.
REQ-004 eligible SHALL be req & ~served.
REQ-005 FSM SHALL have states IDLE, SEND, BUSY.
REQ-006 IDLE: if eligible is nonzero, SHALL latch winner index and its req_shift, then enter SEND next cycle; otherwise stay in IDLE.
REQ-007 Winner SHALL be the first eligible channel at or after round-robin pointer rr_ptr, searching upward with wrap.
REQ-008 SEND: m_tvalid=1 and m_tdata=latched shift, both stable until m_tvalid&m_tready; a req drop SHALL NOT retract tvalid.
REQ-009 On handshake, gnt[winner] SHALL pulse 1 cycle, served[winner] SHALL set, rr_ptr SHALL become (winner+1) mod NUM_REQ, and the FSM SHALL enter BUSY.
REQ-010 BUSY SHALL last exactly CODE_LEN cycles, then return to IDLE; minimum grant-to-grant spacing SHALL be CODE_LEN+2 cycles.
REQ-011 Epoch counter SHALL run freely from EPOCH_CYCLES-1 down to 0; at 0 it SHALL pulse epoch_tick and reload.
REQ-012 On epoch_tick, served SHALL clear; a same-cycle handshake SHALL leave served = only that winner's bit.
REQ-013 On epoch_tick, if (req & ~served) is nonzero (evaluated before the clear), miss_err SHALL set.
REQ-014 err_clr SHALL clear miss_err; a simultaneous set SHALL win.
REQ-015 epoch_tick SHALL NOT abort SEND or BUSY.
REQ-016 Counter widths: $clog2(EPOCH_CYCLES) for the epoch counter, $clog2(CODE_LEN+1) for the busy counter, $clog2(NUM_REQ) for rr_ptr.

Reset
REQ-017 rstn low SHALL asynchronously force the following, aborting any transfer mid-operation:
- state=IDLE, m_tvalid=0, m_tdata=0, gnt=0.
- served=0, rr_ptr=0, busy=0, miss_err=0.
- epoch counter=EPOCH_CYCLES-1, epoch_tick=0.
REQ-018 First epoch_tick SHALL occur EPOCH_CYCLES cycles after rstn deasserts.

Structure
REQ-019 Shared package gold_pkg SHALL hold the FSM state enum and default constants CODE_LEN, SHIFT_W and EPOCH_CYCLES.
REQ-020 Round-robin selection SHALL be one sub-module rr_arbiter (inputs eligible and rr_ptr; outputs valid flag and index).

Verification (bench: NUM_REQ=4, CODE_LEN=63, EPOCH_CYCLES=1000)
REQ-021 req=0001, req_shift[0]=5, m_tready=1 -> m_tvalid at cycle 1 with tdata=5; gnt=0001 at cycle 1; busy cycles 2-64; IDLE at 65.
REQ-022 req=1111, shifts 3/7/9/11 -> grants in order 0,1,2,3 at 65-cycle spacing; served=1111; no fifth grant before epoch_tick.
REQ-023 m_tready held 0 for 10 cycles in SEND while req drops -> tvalid and tdata stay stable; grant issues on first ready cycle.
REQ-024 req=1111 with m_tready=0 across epoch_tick -> miss_err=1 after tick; err_clr pulse -> miss_err=0.
REQ-025 Handshake coincident with epoch_tick for channel 2 -> served=0100 next cycle.
REQ-026 rstn pulsed low mid-BUSY -> all outputs at reset values immediately; first epoch_tick 1000 cycles after release.
